wb_byte_master: RTL and testbench

Wishbone initiator that packs an incoming byte stream into 32-bit little-endian words and writes them to a Wishbone word-addressed memory, such as the on-chip SRAM. It sits between the SIM byte receiver and the SRAM slave port and captures received APDU/ATR bytes into a buffer at a software-programmed base address. It handles partial-word flush, buffer capacity limits and a bus timeout.

---
 rtl/wb_byte_master.sv | 197 +++++++++++++++++++
 tb/tb_wb_byte_master.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_master.sv
// Wishbone initiator: packs a byte stream into 32-bit little-endian words and
// writes them to a word-addressed buffer, with capacity limit and bus timeout.
module wb_byte_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_adr_i,
  input  logic [15:0] max_words_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  input  logic        flush_i,
  output logic        busy_o,
  output logic [15:0] word_count_o,
  output logic        overflow_o,
  output logic        err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i
);

  // state | meaning
  // IDLE  | waiting for start, stream not accepted
  // FILL  | accepting bytes into the packer
  // WRITE | Wishbone write cycle outstanding
  // ERROR | bus timeout seen, waiting for start
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [15:0] max_q, max_d;
  logic [31:0] pk_dat_q, pk_dat_d;
  logic [3:0]  pk_sel_q, pk_sel_d;
  logic [2:0]  pk_cnt_q, pk_cnt_d;
  logic [15:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic [15:0] to_q, to_d;
  logic        cyc_q, cyc_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;

  logic [31:0] acc_dat;
  logic [3:0]  acc_sel;
  logic [2:0]  acc_cnt;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    max_d    = max_q;
    pk_dat_d = pk_dat_q;
    pk_sel_d = pk_sel_q;
    pk_cnt_d = pk_cnt_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    to_d     = to_q;
    cyc_d    = cyc_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    acc_dat  = pk_dat_q;
    acc_sel  = pk_sel_q;
    acc_cnt  = pk_cnt_q;

    if (start_i) begin
      // restart wins over ack and timeout; any in-flight cycle is abandoned
      state_d  = FILL;
      base_d   = base_adr_i & 32'hFFFF_FFFC;
      max_d    = max_words_i;
      pk_dat_d = 32'h0;
      pk_sel_d = 4'h0;
      pk_cnt_d = 3'd0;
      count_d  = 16'h0;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
      to_d     = 16'h0;
      cyc_d    = 1'b0;
      adr_d    = 32'h0;
      dat_d    = 32'h0;
      sel_d    = 4'h0;
    end else begin
      unique case (state_q)
        IDLE: ;
        FILL: begin
          if (byte_valid_i) begin
            if (count_q == max_q) begin
              ovf_d = 1'b1;
            end else begin
              acc_dat[{pk_cnt_q[1:0], 3'b000} +: 8] = byte_i;
              acc_sel[pk_cnt_q[1:0]]                = 1'b1;
              acc_cnt                               = pk_cnt_q + 3'd1;
            end
          end
          // the flush sees the byte accepted in the same cycle
          if ((acc_cnt == 3'd4) || (flush_i && (acc_cnt != 3'd0))) begin
            state_d  = WRITE;
            cyc_d    = 1'b1;
            adr_d    = base_q + {14'd0, count_q, 2'b00};
            dat_d    = acc_dat;
            sel_d    = acc_sel;
            to_d     = TO_LOAD;
            pk_dat_d = 32'h0;
            pk_sel_d = 4'h0;
            pk_cnt_d = 3'd0;
          end else begin
            pk_dat_d = acc_dat;
            pk_sel_d = acc_sel;
            pk_cnt_d = acc_cnt;
          end
        end
        WRITE: begin
          if (wb_ack_i) begin
            state_d = FILL;
            count_d = count_q + 16'd1;
            cyc_d   = 1'b0;
            adr_d   = 32'h0;
            dat_d   = 32'h0;
            sel_d   = 4'h0;
          end else if (to_q == 16'd0) begin
            state_d = ERROR;
            err_d   = 1'b1;
            cyc_d   = 1'b0;
            adr_d   = 32'h0;
            dat_d   = 32'h0;
            sel_d   = 4'h0;
          end else begin
            to_d = to_q - 16'd1;
          end
        end
        ERROR: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      base_q   <= 32'h0;
      max_q    <= 16'h0;
      pk_dat_q <= 32'h0;
      pk_sel_q <= 4'h0;
      pk_cnt_q <= 3'd0;
      count_q  <= 16'h0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 16'h0;
      cyc_q    <= 1'b0;
      adr_q    <= 32'h0;
      dat_q    <= 32'h0;
      sel_q    <= 4'h0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      max_q    <= max_d;
      pk_dat_q <= pk_dat_d;
      pk_sel_q <= pk_sel_d;
      pk_cnt_q <= pk_cnt_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      to_q     <= to_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
    end
  end

  assign byte_ready_o = (state_q == FILL);
  assign busy_o       = (state_q == WRITE) || (pk_cnt_q != 3'd0);
  assign word_count_o = count_q;
  assign overflow_o   = ovf_q;
  assign err_o        = err_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = cyc_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = sel_q;

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master with a Wishbone slave model of
// programmable ack latency that logs every acknowledged write.
module tb_wb_byte_master;

  logic        clk = 1'b0;
  logic        rst, start, flush, valid, wb_ack;
  logic [7:0]  byte_d;
  logic [31:0] base;
  logic [15:0] maxw;
  logic        byte_ready_o, busy_o, overflow_o, err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] word_count_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;

  int checks = 0;
  int failures = 0;

  int          wr_n = 0;
  logic [31:0] log_adr [64];
  logic [31:0] log_dat [64];
  logic [3:0]  log_sel [64];
  int          ack_lat = 1;
  bit          no_ack = 1'b0;
  int          stab_err = 0;

  wb_byte_master #(.TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .base_adr_i(base), .max_words_i(maxw),
    .byte_i(byte_d), .byte_valid_i(valid), .byte_ready_o(byte_ready_o),
    .flush_i(flush), .busy_o(busy_o), .word_count_o(word_count_o),
    .overflow_o(overflow_o), .err_o(err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack)
  );

  initial forever #5 clk = ~clk;

  // slave: acks in the (ack_lat+1)-th strobe cycle, checks held outputs
  initial begin
    int age;
    logic [31:0] h_adr, h_dat;
    logic [3:0]  h_sel;
    logic        h_we;
    age = 0; wb_ack = 1'b0;
    h_adr = '0; h_dat = '0; h_sel = '0; h_we = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (wb_stb_o === 1'b1) begin
        age++;
        if (age == 1) begin
          h_adr = wb_adr_o; h_dat = wb_dat_o; h_sel = wb_sel_o; h_we = wb_we_o;
        end else if (wb_adr_o !== h_adr || wb_dat_o !== h_dat ||
                     wb_sel_o !== h_sel || wb_we_o !== h_we) begin
          stab_err++;
        end
        if (!no_ack && age == ack_lat + 1) begin
          wb_ack = 1'b1;
          if (wr_n < 64) begin
            log_adr[wr_n] = wb_adr_o; log_dat[wr_n] = wb_dat_o; log_sel[wr_n] = wb_sel_o;
          end
          wr_n++;
        end
      end else begin
        age = 0;
        wb_ack = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, need finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] m);
    base = b; maxw = m; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fl);
    int t;
    byte_d = b; valid = 1'b1; flush = fl; t = 0;
    while (byte_ready_o !== 1'b1 && t < 100) begin tick(); t++; end
    if (t >= 100) begin
      checks++; failures++;
      $display("FAIL send_ready: ready=%b after %0d cycles, need 1", byte_ready_o, t);
    end
    tick();
    valid = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((busy_o !== 1'b0 || wb_cyc_o !== 1'b0) && t < 200) begin tick(); t++; end
    if (t >= 200) begin
      checks++; failures++;
      $display("FAIL %s_idle: busy=%b cyc=%b after %0d cycles, need 0", name, busy_o, wb_cyc_o, t);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; valid = 1'b0; byte_d = 8'h00;
    base = 32'h0; maxw = 16'h0;
    tick(); tick();
    checks++; if (byte_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b need 0", byte_ready_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b need 0", busy_o); end
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin failures++; $display("FAIL rst_cyc: got %b need 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'h0) begin failures++; $display("FAIL rst_bus: adr=%h dat=%h sel=%h need 0", wb_adr_o, wb_dat_o, wb_sel_o); end
    checks++; if ({word_count_o, overflow_o, err_o} !== 18'h0) begin failures++; $display("FAIL rst_status: wc=%0d ovf=%b err=%b need 0", word_count_o, overflow_o, err_o); end
    rst = 1'b0;
    flush = 1'b1; valid = 1'b1; byte_d = 8'h5A;
    tick(); tick();
    flush = 1'b0; valid = 1'b0;
    checks++; if ({byte_ready_o, wb_cyc_o, busy_o} !== 3'b000) begin failures++; $display("FAIL idle_ignore: ready/cyc/busy=%b need 000", {byte_ready_o, wb_cyc_o, busy_o}); end
  endtask

  task automatic test_full_words();
    int w0;
    w0 = wr_n;
    do_start(32'h0000_0100, 16'd4);
    checks++; if (byte_ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready: got %b need 1", byte_ready_o); end
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    checks++; if ({wb_cyc_o, wb_stb_o, byte_ready_o} !== 3'b110) begin failures++; $display("FAIL full_cyc_rise: cyc/stb/ready=%b need 110", {wb_cyc_o, wb_stb_o, byte_ready_o}); end
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0); send_byte(8'h77, 1'b0); send_byte(8'h88, 1'b0);
    wait_done("full");
    checks++; if (wr_n - w0 !== 2) begin failures++; $display("FAIL full_nwr: got %0d writes need 2", wr_n - w0); end
    checks++; if ({log_adr[w0], log_dat[w0], log_sel[w0]} !== {32'h0000_0100, 32'h4433_2211, 4'hF}) begin failures++; $display("FAIL full_w0: adr=%h dat=%h sel=%h need 00000100 44332211 f", log_adr[w0], log_dat[w0], log_sel[w0]); end
    checks++; if ({log_adr[w0+1], log_dat[w0+1], log_sel[w0+1]} !== {32'h0000_0104, 32'h8877_6655, 4'hF}) begin failures++; $display("FAIL full_w1: adr=%h dat=%h sel=%h need 00000104 88776655 f", log_adr[w0+1], log_dat[w0+1], log_sel[w0+1]); end
    checks++; if (word_count_o !== 16'd2) begin failures++; $display("FAIL full_wc: got %0d need 2", word_count_o); end
  endtask

  task automatic test_partial_flush();
    int w0;
    w0 = wr_n;
    do_start(32'h0000_0200, 16'd4);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL part_busy: got %b need 1", busy_o); end
    flush = 1'b1; tick(); flush = 1'b0;
    wait_done("part");
    checks++; if (wr_n - w0 !== 1) begin failures++; $display("FAIL part_nwr: got %0d need 1", wr_n - w0); end
    checks++; if ({log_adr[w0], log_dat[w0], log_sel[w0]} !== {32'h0000_0200, 32'h0000_BBAA, 4'b0011}) begin failures++; $display("FAIL part_w0: adr=%h dat=%h sel=%b need 00000200 0000bbaa 0011", log_adr[w0], log_dat[w0], log_sel[w0]); end
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b1);
    wait_done("part_co");
    checks++; if ({log_adr[w0+1], log_dat[w0+1], log_sel[w0+1]} !== {32'h0000_0204, 32'h0000_BBAA, 4'b0011}) begin failures++; $display("FAIL part_coinc: adr=%h dat=%h sel=%b need 00000204 0000bbaa 0011", log_adr[w0+1], log_dat[w0+1], log_sel[w0+1]); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (wb_cyc_o !== 1'b0) begin failures++; $display("FAIL empty_flush_cyc: got %b need 0", wb_cyc_o); end
    tick(); tick(); tick();
    checks++; if ({wr_n - w0, 16'(word_count_o)} !== {32'd2, 16'd2}) begin failures++; $display("FAIL empty_flush: writes=%0d wc=%0d need 2 2", wr_n - w0, word_count_o); end
  endtask

  task automatic test_overflow();
    int w0;
    w0 = wr_n;
    do_start(32'h0000_0300, 16'd1);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    wait_done("ovf");
    checks++; if (wr_n - w0 !== 1) begin failures++; $display("FAIL ovf_nwr: got %0d need 1", wr_n - w0); end
    checks++; if (log_dat[w0] !== 32'h0403_0201) begin failures++; $display("FAIL ovf_dat: got %h need 04030201", log_dat[w0]); end
    checks++; if ({overflow_o, word_count_o, busy_o} !== {1'b1, 16'd1, 1'b0}) begin failures++; $display("FAIL ovf_status: ovf=%b wc=%0d busy=%b need 1 1 0", overflow_o, word_count_o, busy_o); end
    w0 = wr_n;
    do_start(32'h0000_0400, 16'd0);
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b need 0", overflow_o); end
    send_byte(8'hC3, 1'b0);
    checks++; if ({overflow_o, wb_cyc_o, busy_o} !== 3'b100) begin failures++; $display("FAIL ovf_max0: ovf/cyc/busy=%b need 100", {overflow_o, wb_cyc_o, busy_o}); end
    flush = 1'b1; tick(); tick(); flush = 1'b0;
    checks++; if ({wr_n - w0, 16'(word_count_o)} !== {32'd0, 16'd0}) begin failures++; $display("FAIL ovf_max0_wr: writes=%0d wc=%0d need 0 0", wr_n - w0, word_count_o); end
  endtask

  task automatic test_timeout();
    int n, w0;
    no_ack = 1'b1;
    do_start(32'h0000_0500, 16'd4);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    n = 0;
    while (wb_stb_o === 1'b1 && n < 50) begin n++; tick(); end
    checks++; if (n !== 8) begin failures++; $display("FAIL to_len: stb high %0d cycles need 8", n); end
    checks++; if ({err_o, wb_cyc_o, byte_ready_o} !== 3'b100) begin failures++; $display("FAIL to_status: err/cyc/ready=%b need 100", {err_o, wb_cyc_o, byte_ready_o}); end
    tick(); tick();
    checks++; if ({err_o, byte_ready_o, word_count_o} !== {1'b1, 1'b0, 16'd0}) begin failures++; $display("FAIL to_hold: err=%b ready=%b wc=%0d need 1 0 0", err_o, byte_ready_o, word_count_o); end
    no_ack = 1'b0;
    w0 = wr_n;
    do_start(32'h0000_0600, 16'd4);
    checks++; if ({err_o, byte_ready_o} !== 2'b01) begin failures++; $display("FAIL to_restart: err/ready=%b need 01", {err_o, byte_ready_o}); end
    send_byte(8'h0A, 1'b0); send_byte(8'h0B, 1'b0); send_byte(8'h0C, 1'b0); send_byte(8'h0D, 1'b0);
    wait_done("to_resume");
    checks++; if ({wr_n - w0, log_adr[w0], log_dat[w0], 16'(word_count_o)} !== {32'd1, 32'h0000_0600, 32'h0D0C_0B0A, 16'd1}) begin failures++; $display("FAIL to_resume: writes=%0d adr=%h dat=%h wc=%0d need 1 00000600 0d0c0b0a 1", wr_n - w0, log_adr[w0], log_dat[w0], word_count_o); end
  endtask

  task automatic test_ack_latency_wrap();
    int w0, t;
    w0 = wr_n;
    ack_lat = 3;
    do_start(32'hFFFF_FFFC, 16'd4);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    #1; t = 0;
    while (wb_ack !== 1'b1 && t < 20) begin @(posedge clk); #2; t++; end
    checks++; if ({wb_ack, wb_stb_o, byte_ready_o} !== 3'b110) begin failures++; $display("FAIL lat_ack_cycle: ack/stb/ready=%b need 110", {wb_ack, wb_stb_o, byte_ready_o}); end
    @(posedge clk); #1;
    checks++; if ({wb_stb_o, wb_cyc_o, byte_ready_o} !== 3'b001) begin failures++; $display("FAIL lat_after_ack: stb/cyc/ready=%b need 001", {wb_stb_o, wb_cyc_o, byte_ready_o}); end
    send_byte(8'h05, 1'b0); send_byte(8'h06, 1'b0); send_byte(8'h07, 1'b0); send_byte(8'h08, 1'b0);
    wait_done("lat");
    ack_lat = 1;
    checks++; if ({log_adr[w0], log_dat[w0]} !== {32'hFFFF_FFFC, 32'h0403_0201}) begin failures++; $display("FAIL wrap_w0: adr=%h dat=%h need fffffffc 04030201", log_adr[w0], log_dat[w0]); end
    checks++; if ({log_adr[w0+1], log_dat[w0+1]} !== {32'h0000_0000, 32'h0807_0605}) begin failures++; $display("FAIL wrap_w1: adr=%h dat=%h need 00000000 08070605", log_adr[w0+1], log_dat[w0+1]); end
    checks++; if ({wr_n - w0, 16'(word_count_o)} !== {32'd2, 16'd2}) begin failures++; $display("FAIL wrap_count: writes=%0d wc=%0d need 2 2", wr_n - w0, word_count_o); end
    checks++; if (stab_err !== 0) begin failures++; $display("FAIL bus_stable: %0d unstable strobe cycles need 0", stab_err); end
  endtask

  task automatic test_reset_restart();
    int w0;
    no_ack = 1'b1;
    do_start(32'h0000_0700, 16'd4);
    send_byte(8'h21, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h23, 1'b0); send_byte(8'h24, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({byte_ready_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o, overflow_o, err_o} !== 7'b0) begin failures++; $display("FAIL midrst_ctl: ready/busy/cyc/stb/we/ovf/err=%b need 0", {byte_ready_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o, overflow_o, err_o}); end
    checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o, word_count_o} !== 84'h0) begin failures++; $display("FAIL midrst_bus: adr=%h dat=%h sel=%h wc=%0d need 0", wb_adr_o, wb_dat_o, wb_sel_o, word_count_o); end
    no_ack = 1'b0;
    do_start(32'h0000_0800, 16'd4);
    send_byte(8'h31, 1'b0); send_byte(8'h32, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h34, 1'b0);
    wait_done("restart_pre");
    no_ack = 1'b1;
    send_byte(8'h41, 1'b0); send_byte(8'h42, 1'b0); send_byte(8'h43, 1'b0); send_byte(8'h44, 1'b0);
    checks++; if ({wb_cyc_o, wb_adr_o, wb_dat_o} !== {1'b1, 32'h0000_0804, 32'h4443_4241}) begin failures++; $display("FAIL restart_wr: cyc=%b adr=%h dat=%h need 1 00000804 44434241", wb_cyc_o, wb_adr_o, wb_dat_o); end
    tick();
    do_start(32'h0000_0900, 16'd4);
    checks++; if ({wb_cyc_o, wb_stb_o, word_count_o, byte_ready_o} !== {1'b0, 1'b0, 16'd0, 1'b1}) begin failures++; $display("FAIL restart_clr: cyc=%b stb=%b wc=%0d ready=%b need 0 0 0 1", wb_cyc_o, wb_stb_o, word_count_o, byte_ready_o); end
    no_ack = 1'b0;
    w0 = wr_n;
    send_byte(8'h51, 1'b0); send_byte(8'h52, 1'b0); send_byte(8'h53, 1'b0); send_byte(8'h54, 1'b0);
    wait_done("restart_post");
    checks++; if ({wr_n - w0, log_adr[w0], log_dat[w0], 16'(word_count_o)} !== {32'd1, 32'h0000_0900, 32'h5453_5251, 16'd1}) begin failures++; $display("FAIL restart_base: writes=%0d adr=%h dat=%h wc=%0d need 1 00000900 54535251 1", wr_n - w0, log_adr[w0], log_dat[w0], word_count_o); end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial_flush();
    test_overflow();
    test_timeout();
    test_ack_latency_wrap();
    test_reset_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
